// File: rtl/flash_pulse_timer.sv
// flash_pulse_timer: paces colour-flash sequences with a power-of-two pulse rate and bounded bursts.
// Define FLASH_PULSE_TIMER_PHASE_EN to enable the half-period `phase` output (tied low otherwise).
module flash_pulse_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BASE_HZ   = 1,
  parameter int SPEED_W   = 3,
  parameter int MAX_SPEED = 4,
  parameter int NUM_W     = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_speed,
  input  logic [SPEED_W-1:0] speed,
  input  logic               start,
  input  logic [NUM_W-1:0]   num_pulses,
  input  logic               stop,
  input  logic               hold,
  output logic               pulse,
  output logic               done,
  output logic               busy,
  output logic [NUM_W-1:0]   pulse_idx,
  output logic               phase
);

  localparam int RATIO = CLK_HZ / BASE_HZ;
  localparam int CW    = (RATIO > 2) ? $clog2(RATIO) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [SPEED_W-1:0] spd_q;
  logic [SPEED_W-1:0] spd_next;
  logic [CW-1:0]      cnt;
  logic [NUM_W-1:0]   num_q;
  logic [NUM_W-1:0]   idx_inc;

  // Period in clocks for a speed code, saturated at MAX_SPEED and never below 2.
  function automatic int period_int(input logic [SPEED_W-1:0] s);
    int sc;
    int p;
    sc = (int'(s) > MAX_SPEED) ? MAX_SPEED : int'(s);
    p  = CLK_HZ / (BASE_HZ << sc);
    if (p < 2) p = 2;
    return p;
  endfunction

  function automatic logic [CW-1:0] period_m1(input logic [SPEED_W-1:0] s);
    return CW'(period_int(s) - 1);
  endfunction

  assign spd_next = load_speed ? speed : spd_q;
  assign idx_inc  = pulse_idx + NUM_W'(1);
  assign busy     = (state == RUN);

  // The pulse is registered on the edge where the counter steps 1 -> 0, so it is
  // visible exactly in the cycle the counter reads zero; the next edge reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      spd_q     <= '0;
      cnt       <= period_m1('0);
      num_q     <= '0;
      pulse_idx <= '0;
      pulse     <= 1'b0;
      done      <= 1'b0;
    end else begin
      pulse <= 1'b0;
      done  <= 1'b0;
      if (load_speed) spd_q <= speed;
      case (state)
        IDLE: begin
          if (!stop && start) begin
            state     <= RUN;
            cnt       <= period_m1(spd_next);
            pulse_idx <= '0;
            num_q     <= num_pulses;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            cnt       <= period_m1(spd_next);
            pulse_idx <= '0;
            num_q     <= num_pulses;
          end else if (done) begin
            state <= IDLE;
          end else if (load_speed) begin
            cnt <= period_m1(speed);
          end else if (!hold) begin
            if (cnt == '0) begin
              cnt <= period_m1(spd_q);
            end else if (cnt == CW'(1)) begin
              cnt       <= '0;
              pulse     <= 1'b1;
              pulse_idx <= idx_inc;
              if (num_q != '0 && idx_inc == num_q) done <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FLASH_PULSE_TIMER_PHASE_EN
  function automatic logic [CW-1:0] period_half(input logic [SPEED_W-1:0] s);
    return CW'(period_int(s) / 2);
  endfunction

  assign phase = (state == RUN) && (cnt >= period_half(spd_q));
`else
  assign phase = 1'b0;
`endif

endmodule
